// File: rtl/fp_mul_param.sv
// rtl/fp_mul_param.sv - multi-cycle parameterised IEEE-754-style multiplier
// Fixed five-edge latency: UNPACK, MUL, NORM, ROUND, then result held in DONE.
module fp_mul_param #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [EXP_W+MAN_W:0]   a,
  input  logic [EXP_W+MAN_W:0]   b,
  input  logic [1:0]             rnd,
  output logic [EXP_W+MAN_W:0]   z,
  output logic [3:0]             flags,
  output logic                   out_valid,
  input  logic                   out_ready
);

  localparam int W    = 1 + EXP_W + MAN_W;
  localparam int M    = MAN_W;
  localparam int PW   = 2 * M + 2;
  localparam int SW   = 2 * M + 1;
  localparam int EW   = EXP_W + 3;
  localparam int BIAS = (1 << (EXP_W - 1)) - 1;
  localparam int EMAX = (1 << EXP_W) - 2;
  localparam logic [W-1:0] QNAN = {1'b0, {EXP_W{1'b1}}, 1'b1, {(M-1){1'b0}}};

  typedef enum logic [2:0] {IDLE, UNPACK, MUL, NORM, ROUND, DONE} state_t;
  state_t state;

  logic [W-1:0]          ra, rb;
  logic [1:0]            rrnd;
  logic                  sign;
  logic signed [EW-1:0]  ea_r, eb_r, pexp, nexp;
  logic [M:0]            ma_r, mb_r;
  logic                  sp;
  logic [W-1:0]          sp_z;
  logic [3:0]            sp_f;
  logic [PW-1:0]         prod;
  logic [SW-1:0]         nsig;
  logic                  nsticky, ntiny;

  function automatic logic [7:0] lzc(input logic [M:0] v);
    lzc = 8'(M + 1);
    for (int i = 0; i <= M; i++)
      if (v[i]) lzc = 8'(M - i);
  endfunction

  // Unpack: classify operands and left-justify subnormal significands
  logic [EXP_W-1:0]     xa, xb;
  logic [M-1:0]         fa, fb;
  logic [7:0]           lza, lzb;
  logic [M:0]           ma_c, mb_c;
  logic signed [EW-1:0] ea_c, eb_c;
  logic                 s_c, a_nan, b_nan, a_snan, b_snan, a_inf, b_inf, a_zero, b_zero;
  logic                 sp_c;
  logic [W-1:0]         sp_z_c;
  logic [3:0]           sp_f_c;

  assign xa  = ra[W-2:M];
  assign xb  = rb[W-2:M];
  assign fa  = ra[M-1:0];
  assign fb  = rb[M-1:0];
  assign s_c = ra[W-1] ^ rb[W-1];

  always_comb begin
    lza    = lzc({1'b0, fa});
    lzb    = lzc({1'b0, fb});
    ma_c   = (xa != '0) ? {1'b1, fa} : ({1'b0, fa} << lza);
    mb_c   = (xb != '0) ? {1'b1, fb} : ({1'b0, fb} << lzb);
    ea_c   = (xa != '0) ? EW'(xa) : EW'(1) - EW'(lza);
    eb_c   = (xb != '0) ? EW'(xb) : EW'(1) - EW'(lzb);
    a_nan  = (&xa) && (|fa);
    b_nan  = (&xb) && (|fb);
    a_snan = a_nan && !fa[M-1];
    b_snan = b_nan && !fb[M-1];
    a_inf  = (&xa) && !(|fa);
    b_inf  = (&xb) && !(|fb);
    a_zero = !(|xa) && !(|fa);
    b_zero = !(|xb) && !(|fb);
    sp_c   = 1'b1;
    sp_z_c = QNAN;
    sp_f_c = 4'b0000;
    if (a_nan || b_nan)
      sp_f_c = {a_snan || b_snan, 3'b000};
    else if ((a_inf && b_zero) || (b_inf && a_zero))
      sp_f_c = 4'b1000;
    else if (a_inf || b_inf)
      sp_z_c = {s_c, {EXP_W{1'b1}}, {M{1'b0}}};
    else if (a_zero || b_zero)
      sp_z_c = {s_c, {(W-1){1'b0}}};
    else
      sp_c = 1'b0;
  end

  // Normalise: fold a 2.x product to 1.x, then denormalise tiny results
  logic signed [EW-1:0] ne, diff;
  logic [SW-1:0]        pre_sig;
  logic                 pre_st, tiny_c;
  logic [7:0]           sh;
  logic [2*SW-1:0]      ext;

  always_comb begin
    if (prod[PW-1]) begin
      pre_sig = prod[PW-1:1];
      pre_st  = prod[0];
      ne      = pexp + EW'(1);
    end else begin
      pre_sig = prod[SW-1:0];
      pre_st  = 1'b0;
      ne      = pexp;
    end
    tiny_c = ne < $signed(EW'(1));
    diff   = EW'(1) - ne;
    if (!tiny_c)
      sh = 8'd0;
    else if (diff > $signed(EW'(M + 3)))
      sh = 8'(M + 3);
    else
      sh = 8'(diff);
    ext = {pre_sig, {SW{1'b0}}} >> sh;
  end

  // Round: guard/round/sticky below the M+1 kept significand bits
  logic [M:0]           mant, fm;
  logic [M+1:0]         mr;
  logic                 g, r, s, inex, up, ovf, to_inf;
  logic signed [EW-1:0] re;
  logic [EXP_W-1:0]     field;
  logic [W-1:0]         z_c;
  logic [3:0]           f_c;

  always_comb begin
    mant = nsig[SW-1:M];
    g    = nsig[M-1];
    r    = nsig[M-2];
    s    = (|nsig[M-3:0]) | nsticky;
    inex = g | r | s;
    case (rrnd)
      2'd0:    up = g && (r || s || mant[0]);
      2'd1:    up = 1'b0;
      2'd2:    up = !sign && inex;
      default: up = sign && inex;
    endcase
    mr = {1'b0, mant} + (M+2)'(up);
    if (mr[M+1]) begin
      fm = mr[M+1:1];
      re = nexp + EW'(1);
    end else begin
      fm = mr[M:0];
      re = nexp;
    end
    field  = fm[M] ? re[EXP_W-1:0] : '0;
    ovf    = re > $signed(EW'(EMAX));
    to_inf = (rrnd == 2'd0) || (rrnd == 2'd2 && !sign) || (rrnd == 2'd3 && sign);
    if (sp) begin
      z_c = sp_z;
      f_c = sp_f;
    end else if (ovf) begin
      z_c = to_inf ? {sign, {EXP_W{1'b1}}, {M{1'b0}}}
                   : {sign, {(EXP_W-1){1'b1}}, 1'b0, {M{1'b1}}};
      f_c = 4'b0101;
    end else begin
      z_c = {sign, field, fm[M-1:0]};
      f_c = {2'b00, ntiny && inex, inex};
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      z         <= '0;
      flags     <= '0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          ra       <= a;
          rb       <= b;
          rrnd     <= rnd;
          in_ready <= 1'b0;
          state    <= UNPACK;
        end
        UNPACK: begin
          sign  <= s_c;
          ea_r  <= ea_c;
          eb_r  <= eb_c;
          ma_r  <= ma_c;
          mb_r  <= mb_c;
          sp    <= sp_c;
          sp_z  <= sp_z_c;
          sp_f  <= sp_f_c;
          state <= MUL;
        end
        MUL: begin
          prod  <= PW'(ma_r) * PW'(mb_r);
          pexp  <= ea_r + eb_r - EW'(BIAS);
          state <= NORM;
        end
        NORM: begin
          nsig    <= ext[2*SW-1:SW];
          nsticky <= pre_st | (|ext[SW-1:0]);
          nexp    <= tiny_c ? EW'(1) : ne;
          ntiny   <= tiny_c;
          state   <= ROUND;
        end
        ROUND: begin
          z         <= z_c;
          flags     <= f_c;
          out_valid <= 1'b1;
          state     <= DONE;
        end
        DONE: if (out_ready) begin
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fp_mul_param.sv
// tb/tb_fp_mul_param.sv - scoreboard bench for fp_mul_param (binary32 and binary16 instances)
module tb_fp_mul_param;

  logic        clk = 1'b0;
  logic        rst_n, in_valid, in_ready, out_valid, out_ready;
  logic [31:0] a, b, z;
  logic [1:0]  rnd;
  logic [3:0]  flags;

  logic        h_rst_n, h_in_valid, h_in_ready, h_out_valid, h_out_ready;
  logic [15:0] h_a, h_b, h_z;
  logic [1:0]  h_rnd;
  logic [3:0]  h_flags;

  int tests = 0, fails = 0, cyc = 0;
  bit main_done = 0, half_done = 0, prev_ov = 0;

  logic [31:0] exp_z[$];
  logic [3:0]  exp_f[$];
  int          exp_cap[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  fp_mul_param dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .rnd(rnd), .z(z), .flags(flags),
    .out_valid(out_valid), .out_ready(out_ready)
  );

  fp_mul_param #(.EXP_W(5), .MAN_W(10)) dut_h (
    .clk(clk), .rst_n(h_rst_n), .in_valid(h_in_valid), .in_ready(h_in_ready),
    .a(h_a), .b(h_b), .rnd(h_rnd), .z(h_z), .flags(h_flags),
    .out_valid(h_out_valid), .out_ready(h_out_ready)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
    tests++;
    if (act !== expv) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, expv, $time);
    end
  endtask

  // Exact reference: value = P * 2^e, rounded to the quantum of the result's binade
  function automatic logic [67:0] ref_mul(input int E, input int M, input logic [63:0] x,
                                          input logic [63:0] y, input logic [1:0] rm);
    int bias, maxe, xa, xb, ea, eb, e, msb, L, qe, sh, field;
    logic [63:0] mask, fa, fb, ga, gb, P, Q, rem, half, frac, qnan, zz;
    logic sgn, an, bn, asn, bsn, ai, bi, az, bz, inexact, gt, eq, up, tiny, to_inf;
    bias = (1 << (E - 1)) - 1;
    maxe = (1 << E) - 1;
    mask = (64'd1 << M) - 1;
    sgn  = x[E+M] ^ y[E+M];
    xa   = int'((x >> M) & 64'(maxe));
    xb   = int'((y >> M) & 64'(maxe));
    fa   = x & mask;
    fb   = y & mask;
    an   = (xa == maxe) && (fa != 0);
    bn   = (xb == maxe) && (fb != 0);
    asn  = an && !fa[M-1];
    bsn  = bn && !fb[M-1];
    ai   = (xa == maxe) && (fa == 0);
    bi   = (xb == maxe) && (fb == 0);
    az   = (xa == 0) && (fa == 0);
    bz   = (xb == 0) && (fb == 0);
    qnan = (64'(maxe) << M) | (64'd1 << (M - 1));
    if (an || bn) return {asn || bsn, 3'b000, qnan};
    if ((ai && bz) || (bi && az)) return {4'b1000, qnan};
    if (ai || bi) return {4'b0000, (64'(sgn) << (E + M)) | (64'(maxe) << M)};
    if (az || bz) return {4'b0000, 64'(sgn) << (E + M)};
    ga = (xa != 0) ? (fa | (64'd1 << M)) : fa;
    gb = (xb != 0) ? (fb | (64'd1 << M)) : fb;
    ea = ((xa != 0) ? xa : 1) - bias - M;
    eb = ((xb != 0) ? xb : 1) - bias - M;
    P  = ga * gb;
    e  = ea + eb;
    msb = 0;
    for (int i = 0; i < 64; i++) if (P[i]) msb = i;
    L    = msb + e;
    tiny = L < 1 - bias;
    qe   = L - M;
    if (qe < 1 - bias - M) qe = 1 - bias - M;
    sh = qe - e;
    inexact = 0; gt = 0; eq = 0;
    if (sh <= 0) Q = P << (-sh);
    else if (sh >= 62) begin Q = 0; inexact = 1; end
    else begin
      Q = P >> sh;
      rem = P & ((64'd1 << sh) - 1);
      half = 64'd1 << (sh - 1);
      inexact = rem != 0;
      gt = rem > half;
      eq = rem == half;
    end
    case (rm)
      2'd0:    up = gt || (eq && Q[0]);
      2'd1:    up = 0;
      2'd2:    up = !sgn && inexact;
      default: up = sgn && inexact;
    endcase
    Q = Q + 64'(up);
    if (Q == (64'd1 << (M + 1))) begin Q = Q >> 1; qe++; end
    if (Q >= (64'd1 << M)) begin field = qe + M + bias; frac = Q - (64'd1 << M); end
    else begin field = 0; frac = Q; end
    if (field >= maxe) begin
      to_inf = (rm == 2'd0) || (rm == 2'd2 && !sgn) || (rm == 2'd3 && sgn);
      zz = to_inf ? ((64'(sgn) << (E + M)) | (64'(maxe) << M))
                  : ((64'(sgn) << (E + M)) | (64'(maxe - 1) << M) | mask);
      return {4'b0101, zz};
    end
    zz = (64'(sgn) << (E + M)) | (64'(field) << M) | frac;
    return {2'b00, tiny && inexact, inexact, zz};
  endfunction

  function automatic logic [63:0] rand_op(input int E, input int M);
    int bias, maxe, x;
    logic [63:0] f, sgn;
    bias = (1 << (E - 1)) - 1;
    maxe = (1 << E) - 1;
    f    = {$urandom, $urandom} & ((64'd1 << M) - 1);
    sgn  = 64'($urandom_range(0, 1));
    case ($urandom_range(0, 15))
      0:       begin x = 0; f = 0; end
      1:       begin x = 0; if (f == 0) f = 1; end
      2:       begin x = maxe; f = 0; end
      3:       begin x = maxe; if (f == 0) f = 1; end
      4, 5:    x = maxe - 1 - $urandom_range(0, 2);
      6, 7:    x = $urandom_range(1, 3);
      8, 9:    x = $urandom_range(1, maxe - 1);
      default: x = bias - 3 + $urandom_range(0, 6);
    endcase
    return (sgn << (E + M)) | (64'(x) << M) | f;
  endfunction

  task automatic issue(input logic [31:0] ta, input logic [31:0] tb_v, input logic [1:0] tr,
                       input bit push, input logic [31:0] ez, input logic [3:0] ef);
    int n = 0;
    @(negedge clk);
    while (!in_ready && n < 300) begin @(negedge clk); n++; end
    if (!in_ready) begin
      tests++; fails++;
      $display("FAIL issue_timeout: in_ready stayed 0, required 1");
      return;
    end
    a = ta; b = tb_v; rnd = tr; in_valid = 1'b1;
    @(posedge clk); #1;
    if (push) begin exp_z.push_back(ez); exp_f.push_back(ef); exp_cap.push_back(cyc); end
    in_valid = 1'b0;
    a = $urandom; b = $urandom; rnd = 2'($urandom_range(0, 3));
  endtask

  task automatic drain();
    int n = 0;
    while (exp_z.size() != 0 && n < 2000) begin @(negedge clk); n++; end
    check("drain_queue_empty", 64'(exp_z.size()), 0);
  endtask

  // Monitor / scoreboard for the binary32 instance
  always @(negedge clk) begin
    bit nr;
    if (!rst_n) prev_ov = 0;
    else if (out_valid) begin
      if (exp_z.size() == 0) begin
        tests++; fails++;
        $display("FAIL unexpected_out_valid: got 1, required 0 (t=%0t)", $time);
        out_ready = 1'b1;
      end else begin
        if (!prev_ov) check("latency", 64'(cyc - exp_cap[0]), 4);
        check("z", 64'(z), 64'(exp_z[0]));
        check("flags", 64'(flags), 64'(exp_f[0]));
        check("in_ready_in_done", 64'(in_ready), 0);
        nr = ($urandom_range(0, 3) != 0);
        out_ready = nr;
        if (nr) begin
          void'(exp_z.pop_front()); void'(exp_f.pop_front()); void'(exp_cap.pop_front());
          prev_ov = 0;
        end else prev_ov = 1;
      end
    end else begin
      out_ready = 1'($urandom_range(0, 1));
      prev_ov = 0;
    end
  end

  initial begin
    logic [67:0] rr;
    logic [31:0] ra, rb;
    logic [1:0]  rm;
    rst_n = 0; in_valid = 0; a = 0; b = 0; rnd = 0;
    repeat (2) @(posedge clk);
    @(negedge clk) in_valid = 1'b1;
    @(negedge clk);
    check("rst_in_ready", 64'(in_ready), 1);
    check("rst_out_valid", 64'(out_valid), 0);
    check("rst_z", 64'(z), 0);
    check("rst_flags", 64'(flags), 0);
    in_valid = 1'b0;
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("post_rst_in_ready", 64'(in_ready), 1);

    issue(32'h3FC00000, 32'h40000000, 2'd0, 1, 32'h40400000, 4'b0000);
    issue(32'h7F800000, 32'h00000000, 2'd0, 1, 32'h7FC00000, 4'b1000);
    issue(32'h7F800000, 32'hC0000000, 2'd0, 1, 32'hFF800000, 4'b0000);
    issue(32'h7F7FFFFF, 32'h40000000, 2'd0, 1, 32'h7F800000, 4'b0101);
    issue(32'h7F7FFFFF, 32'h40000000, 2'd1, 1, 32'h7F7FFFFF, 4'b0101);
    issue(32'h7F7FFFFF, 32'h40000000, 2'd2, 1, 32'h7F800000, 4'b0101);
    issue(32'hFF7FFFFF, 32'h40000000, 2'd2, 1, 32'hFF7FFFFF, 4'b0101);
    issue(32'hFF7FFFFF, 32'h40000000, 2'd3, 1, 32'hFF800000, 4'b0101);
    issue(32'h00800001, 32'h3F000000, 2'd0, 1, 32'h00400000, 4'b0011);
    issue(32'h00800000, 32'h3F000000, 2'd0, 1, 32'h00400000, 4'b0000);
    issue(32'h7F800000, 32'h00000000, 2'd3, 1, 32'h7FC00000, 4'b1000);
    issue(32'h7F800001, 32'h3F800000, 2'd1, 1, 32'h7FC00000, 4'b1000);
    issue(32'h7FC00000, 32'h00000000, 2'd2, 1, 32'h7FC00000, 4'b0000);
    issue(32'h80000000, 32'h3F800000, 2'd2, 1, 32'h80000000, 4'b0000);

    for (int i = 0; i < 300; i++) begin
      ra = 32'(rand_op(8, 23));
      rb = 32'(rand_op(8, 23));
      rm = 2'($urandom_range(0, 3));
      rr = ref_mul(8, 23, 64'(ra), 64'(rb), rm);
      issue(ra, rb, rm, 1, rr[31:0], rr[67:64]);
    end
    drain();

    // Abort an operation while it sits in MUL
    issue(32'h3FC00000, 32'h40000000, 2'd0, 0, 32'h0, 4'h0);
    @(posedge clk);
    @(negedge clk) rst_n = 1'b0;
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    check("abort_in_ready", 64'(in_ready), 1);
    repeat (8) @(negedge clk);
    check("abort_no_out_valid", 64'(out_valid), 0);
    issue(32'h40400000, 32'h40000000, 2'd0, 1, 32'h40C00000, 4'b0000);
    drain();
    main_done = 1;
  end

  initial begin
    logic [67:0] rr;
    logic [15:0] ea, eb;
    logic [1:0]  em;
    logic [15:0] ez;
    logic [3:0]  ef;
    int n;
    h_rst_n = 0; h_in_valid = 0; h_a = 0; h_b = 0; h_rnd = 0; h_out_ready = 0;
    repeat (3) @(posedge clk);
    @(negedge clk) h_rst_n = 1'b1;
    for (int i = 0; i < 40; i++) begin
      if (i == 0) begin
        ea = 16'h3C00; eb = 16'hBC00; em = 2'd0; ez = 16'hBC00; ef = 4'b0000;
      end else begin
        ea = 16'(rand_op(5, 10)); eb = 16'(rand_op(5, 10)); em = 2'($urandom_range(0, 3));
        rr = ref_mul(5, 10, 64'(ea), 64'(eb), em);
        ez = rr[15:0]; ef = rr[67:64];
      end
      @(negedge clk);
      n = 0;
      while (!h_in_ready && n < 50) begin @(negedge clk); n++; end
      h_a = ea; h_b = eb; h_rnd = em; h_in_valid = 1'b1;
      @(posedge clk); #1;
      h_in_valid = 1'b0; h_a = 16'($urandom); h_b = 16'($urandom); h_rnd = 2'($urandom_range(0, 3));
      n = 0;
      while (!h_out_valid && n < 20) begin @(posedge clk); #1; n++; end
      check("h_latency", 64'(n), 4);
      for (int k = 0; k < 3; k++) begin
        @(negedge clk);
        check("h_z_hold", 64'(h_z), 64'(ez));
        check("h_in_ready_hold", 64'(h_in_ready), 0);
      end
      check("h_flags", 64'(h_flags), 64'(ef));
      h_out_ready = 1'b1;
      @(posedge clk); #1;
      h_out_ready = 1'b0;
      check("h_out_valid_after_hs", 64'(h_out_valid), 0);
      check("h_in_ready_after_hs", 64'(h_in_ready), 1);
    end
    half_done = 1;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    wait (main_done && half_done);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
